// File: rtl/wb_common.sv
// rtl/wb_common.sv - Wishbone burst encodings and master state type shared by the master and the arbiter.
package wb_common;

  localparam logic [2:0] CTI_CLASSIC   = 3'b000;
  localparam logic [2:0] CTI_INC_BURST = 3'b010;
  localparam logic [2:0] CTI_END_BURST = 3'b111;
  localparam logic [1:0] BTE_LINEAR    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DONE,
    ST_ERR
  } burst_state_t;

  // A zero or oversized length request becomes a full-size burst.
  function automatic logic [3:0] eff_len(input logic [3:0] len, input int max_burst);
    if (len == 4'd0 || int'(len) > max_burst) return 4'(max_burst);
    return len;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - Counts enabled cycles since the last clear; flags the TIMEOUT-th quiet cycle.
module wb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign expired = enable && !clear && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || clear) begin
      r_cnt <= '0;
    end else if (!expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - Command-driven Wishbone incrementing-burst master with read/write streams and ack watchdog.
module wb_burst_master #(
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [3:0]  cmd_len_i,
  input  logic [31:0] wdat_i,
  input  logic [3:0]  wdat_sel_i,
  input  logic        wdat_valid_i,
  output logic        wdat_ready_o,
  output logic [31:0] rdat_o,
  output logic        rdat_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  import wb_common::*;

  burst_state_t r_state, w_next;

  logic        r_we;
  logic [31:0] r_adr;
  logic [3:0]  r_len;
  logic [3:0]  r_beat;
  logic        r_wfull;
  logic [31:0] r_wdat;
  logic [3:0]  r_wsel;
  logic [31:0] r_rdat;
  logic        r_rvalid;

  logic w_stb, w_ack, w_last_beat, w_expired, w_in_burst;
  logic w_unused_adr;

  assign w_unused_adr = ^cmd_adr_i[1:0];
  assign w_in_burst   = (r_state == ST_BURST);
  // A write beat is only strobed while the data register holds it.
  assign w_stb        = w_in_burst && (!r_we || r_wfull);
  assign w_ack        = w_stb && wb_ack_i;
  assign w_last_beat  = (r_beat == r_len - 4'd1);

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (wb_clk),
    .rst_n   (wb_rst_n),
    .clear   (w_ack),
    .enable  (w_in_burst),
    .expired (w_expired)
  );

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    cmd_ready_o  = 1'b0;
    wb_cyc_o     = 1'b0;
    wb_stb_o     = 1'b0;
    wb_we_o      = 1'b0;
    wb_cti_o     = CTI_CLASSIC;
    wdat_ready_o = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = wb_rst_n;
        if (cmd_valid_i && wb_rst_n) w_next = ST_BURST;
      end
      ST_BURST: begin
        wb_cyc_o     = 1'b1;
        wb_stb_o     = w_stb;
        wb_we_o      = r_we;
        wdat_ready_o = r_we && !r_wfull;
        if (r_len == 4'd1)    wb_cti_o = CTI_CLASSIC;
        else if (w_last_beat) wb_cti_o = CTI_END_BURST;
        else                  wb_cti_o = CTI_INC_BURST;
        if (w_ack && w_last_beat) w_next = ST_DONE;
        else if (w_expired)       w_next = ST_ERR;
      end
      ST_DONE: begin
        done_o = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        err_o  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_wfull  <= 1'b0;
      r_wdat   <= '0;
      r_wsel   <= '0;
      r_rdat   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_ack && !r_we;
      if (w_ack && !r_we) r_rdat <= wb_dat_i;

      if (r_state == ST_IDLE && cmd_valid_i) begin
        r_we   <= cmd_we_i;
        r_adr  <= {cmd_adr_i[31:2], 2'b00};
        r_len  <= eff_len(cmd_len_i, MAX_BURST);
        r_beat <= '0;
      end else if (w_ack) begin
        r_adr  <= r_adr + 32'd4;
        r_beat <= r_beat + 4'd1;
      end

      // Leaving the burst (done or abort) discards any beat still held.
      if (wdat_valid_i && wdat_ready_o) begin
        r_wfull <= 1'b1;
        r_wdat  <= wdat_i;
        r_wsel  <= wdat_sel_i;
      end else if (w_ack || !w_in_burst) begin
        r_wfull <= 1'b0;
      end
    end
  end

  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_wdat;
  assign wb_sel_o     = r_wsel;
  assign wb_bte_o     = BTE_LINEAR;
  assign rdat_o       = r_rdat;
  assign rdat_valid_o = r_rvalid;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - Scoreboard bench for wb_burst_master with a queue-based burst model and slave.
module tb_wb_burst_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [3:0]  cmd_len_i;
  logic [31:0] wdat_i;
  logic [3:0]  wdat_sel_i;
  logic        wdat_valid_i, wdat_ready_o;
  logic [31:0] rdat_o;
  logic        rdat_valid_o, done_o, err_o;
  logic [31:0] wb_adr_o;
  logic        wb_stb_o, wb_cyc_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  always #5 wb_clk = ~wb_clk;

  wb_burst_master #(.MAX_BURST(8), .TIMEOUT(16)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdat_i(wdat_i), .wdat_sel_i(wdat_sel_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
    .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rdat[$];
  logic [1:0]  exp_end[$];

  int   n_pass = 0;
  int   n_chk  = 0;
  int   ack_cnt = 0;
  int   ack_mode = 2;
  logic abort = 1'b0;
  logic prev_rack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] slave_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Slave: mode 0 acks always (even with stb low), 1 acks randomly, 2 never acks.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      case (ack_mode)
        0:       wb_ack_i = 1'b1;
        1:       wb_ack_i = wb_stb_o ? ($urandom % 4 != 0) : ($urandom % 2 == 0);
        default: wb_ack_i = 1'b0;
      endcase
      wb_dat_i = slave_f(wb_adr_o);
    end
  end

  always @(negedge wb_clk) begin : monitor
    beat_t h;
    if (!wb_rst_n) begin
      prev_rack = 1'b0;
    end else begin
      if (wb_cyc_o) begin
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", 32'd1, 32'd0);
        end else begin
          h = exp_beats[0];
          chk("wb_adr", wb_adr_o, h.adr);
          chk("wb_cti", {29'd0, wb_cti_o}, {29'd0, h.cti});
          chk("wb_we", {31'd0, wb_we_o}, {31'd0, h.we});
          chk("wb_bte", {30'd0, wb_bte_o}, 32'd0);
          if (!h.we) chk("rd_stb", {31'd0, wb_stb_o}, 32'd1);
          if (wb_stb_o && h.we) begin
            chk("wb_dat", wb_dat_o, h.dat);
            chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, h.sel});
          end
          if (wb_stb_o && wb_ack_i) begin
            void'(exp_beats.pop_front());
            ack_cnt++;
          end
        end
      end
      if (rdat_valid_o || prev_rack) chk("rdat_latency", {31'd0, rdat_valid_o}, {31'd0, prev_rack});
      if (rdat_valid_o) begin
        if (exp_rdat.size() == 0) chk("rdat_unexpected", 32'd1, 32'd0);
        else chk("rdat", rdat_o, exp_rdat.pop_front());
      end
      if (done_o || err_o) begin
        if (exp_end.size() == 0) chk("end_unexpected", {30'd0, err_o, done_o}, 32'd0);
        else chk("end_strobe", {30'd0, err_o, done_o}, {30'd0, exp_end.pop_front()});
      end
      prev_rack = wb_cyc_o && wb_stb_o && wb_ack_i && !wb_we_o;
    end
  end

  task automatic check_reset_vals();
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_rvalid", {31'd0, rdat_valid_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_wready", {31'd0, wdat_ready_o}, 32'd0);
    chk("rst_cti", {29'd0, wb_cti_o}, 32'd0);
    chk("rst_bte", {30'd0, wb_bte_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_rdat", rdat_o, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
  endtask

  // Builds the expected bus beats from the command, handshakes it, then feeds write data.
  // gap_mode: 0 none, 1 idle cycle before every beat, 2 random idle cycles.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] len,
                       input int gap_mode, input logic expect_err);
    int          n;
    logic [31:0] a;
    beat_t       b;
    beat_t       wq[$];
    bit          seen;
    n = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
    a = {adr[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      b.adr = a + 32'(4 * i);
      b.cti = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
      b.we  = we;
      b.dat = $urandom;
      b.sel = 4'($urandom);
      exp_beats.push_back(b);
      if (we) wq.push_back(b);
      else    exp_rdat.push_back(slave_f(b.adr));
    end
    exp_end.push_back(expect_err ? 2'b10 : 2'b01);

    cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len; cmd_valid_i = 1'b1;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready_o) begin seen = 1; break; end
      @(negedge wb_clk);
    end
    if (!seen) chk("cmd_ready_wait", 32'd0, 32'd1);
    @(negedge wb_clk);
    cmd_valid_i = 1'b0;

    foreach (wq[i]) begin
      if (abort) break;
      if (gap_mode == 1 || (gap_mode == 2 && $urandom % 2 == 1)) @(negedge wb_clk);
      wdat_i = wq[i].dat; wdat_sel_i = wq[i].sel; wdat_valid_i = 1'b1;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
        if (abort) break;
        if (wdat_ready_o) begin seen = 1; break; end
        @(negedge wb_clk);
      end
      if (abort) break;
      if (!seen) chk("wdat_ready_wait", 32'd0, 32'd1);
      @(negedge wb_clk);
      wdat_valid_i = 1'b0;
    end
    wdat_valid_i = 1'b0;
  endtask

  task automatic wait_end(output int cyc_cnt);
    bit ok;
    ok = 0;
    cyc_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      cyc_cnt += int'(wb_cyc_o);
      if (done_o || err_o) begin ok = 1; break; end
      @(negedge wb_clk);
    end
    if (!ok) begin
      chk("end_timeout", 32'd0, 32'd1);
    end else begin
      chk("cmd_ready_in_end", {31'd0, cmd_ready_o}, 32'd0);
      @(negedge wb_clk);
      chk("cmd_ready_after_end", {31'd0, cmd_ready_o}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int c;
    int base;
    wb_rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    wdat_i = '0; wdat_sel_i = '0; wdat_valid_i = 1'b0;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    check_reset_vals();
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);

    ack_mode = 0;
    issue(1'b0, 32'h0000_1000, 4'd4, 0, 1'b0);
    wait_end(c);
    issue(1'b1, 32'h0000_0200, 4'd8, 1, 1'b0);
    wait_end(c);
    issue(1'b0, 32'hFFFF_FFFC, 4'd1, 0, 1'b0);
    wait_end(c);
    issue(1'b0, 32'hFFFF_FFFC, 4'd2, 0, 1'b0);
    wait_end(c);

    ack_mode = 2;
    issue(1'b0, 32'h0000_3000, 4'd2, 0, 1'b1);
    wait_end(c);
    chk("timeout_cyc_cycles", 32'(c), 32'd16);
    exp_beats.delete();
    exp_rdat.delete();

    ack_mode = 0;
    base = ack_cnt;
    fork
      issue(1'b1, 32'h0000_0400, 4'd8, 0, 1'b0);
      begin
        bit hit;
        hit = 0;
        for (int k = 0; k < 200; k++) begin
          @(posedge wb_clk);
          #1;
          if (ack_cnt - base >= 3) begin hit = 1; break; end
        end
        if (!hit) chk("reset_ack_wait", 32'd0, 32'd1);
        wb_rst_n = 1'b0;
        abort = 1'b1;
        @(posedge wb_clk);
        #1;
        exp_beats.delete();
        exp_rdat.delete();
        exp_end.delete();
        @(negedge wb_clk);
        check_reset_vals();
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
      end
    join
    abort = 1'b0;
    @(negedge wb_clk);
    chk("cmd_ready_post_reset", {31'd0, cmd_ready_o}, 32'd1);

    ack_mode = 1;
    issue(1'b0, 32'h0000_5003, 4'd0, 0, 1'b0);
    wait_end(c);
    chk("len0_beats_left", 32'(exp_beats.size()), 32'd0);

    for (int t = 0; t < 25; t++) begin
      ack_mode = ($urandom % 3 == 0) ? 0 : 1;
      issue(1'($urandom), $urandom, 4'($urandom), 2, 1'b0);
      wait_end(c);
    end

    repeat (3) @(negedge wb_clk);
    chk("final_beats_left", 32'(exp_beats.size()), 32'd0);
    chk("final_rdat_left", 32'(exp_rdat.size()), 32'd0);
    chk("final_end_left", 32'(exp_end.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, meaning the maximum beats per burst (power of 2, 1..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the wb_clk cycles without ack before a burst is aborted.
REQ-003 SHALL have port wb_clk  in  1  the single clock; all logic on the rising edge.
REQ-004 SHALL have port wb_rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1: the command handshake.
REQ-006 SHALL have ports cmd_we_i in 1, cmd_adr_i in 32, cmd_len_i in 4: direction, word-aligned byte address, and beat count (1..MAX_BURST).
REQ-007 SHALL have ports wdat_i in 32, wdat_sel_i in 4, wdat_valid_i in 1, wdat_ready_o out 1: the write-data stream.
REQ-008 SHALL have ports rdat_o out 32, rdat_valid_o out 1: the read-data stream, with no backpressure.
REQ-009 SHALL have ports done_o out 1 and err_o out 1: one-cycle completion and timeout-abort strobes.
REQ-010 SHALL have WB master ports wb_adr_o 32, wb_stb_o 1, wb_cyc_o 1, wb_cti_o 3, wb_bte_o 2, wb_we_o 1, wb_sel_o 4, wb_dat_o 32 (outputs), plus wb_dat_i 32 and wb_ack_i 1 (inputs).

Function
REQ-011 SHALL implement states IDLE, BURST, DONE, ERR.
REQ-012 IDLE SHALL assert cmd_ready_o; cmd_valid_i&cmd_ready_o latches cmd_* and enters BURST next cycle.
REQ-013 SHALL treat cmd_len_i=0 or >MAX_BURST as MAX_BURST; cmd_adr_i[1:0] SHALL be ignored (forced 00).
REQ-014 BURST SHALL hold wb_cyc_o=1 throughout and set wb_bte_o=2'b00 (linear).
REQ-015 wb_cti_o SHALL be 3'b000 for a 1-beat command, 3'b010 for all non-final beats, and 3'b111 on the final beat.
REQ-016 wb_adr_o SHALL start at the latched address and advance by 4 on each accepted ack, wrapping modulo 2^32.
REQ-017 Read: wb_stb_o=1 each BURST cycle; on wb_ack_i, rdat_o=wb_dat_i and rdat_valid_o=1 in the following cycle (1-cycle latency).
REQ-018 Write: wdat_ready_o=1 only when the output data register is empty; wb_stb_o=1 only while it holds a beat; a missing beat SHALL give stb=0 with cyc and cti held (wait state).
REQ-019 Write: wb_dat_o/wb_sel_o SHALL remain stable from stb assertion until ack; ack empties the register.
REQ-020 wb_ack_i when wb_stb_o=0 SHALL be ignored (counts no beat, emits no data).
REQ-021 After the final ack: cyc/stb deassert next cycle; DONE pulses done_o for 1 cycle, then IDLE.
REQ-022 Beat counter SHALL be 4 bits; the final beat is when the count equals the latched length minus 1.
REQ-023 Watchdog SHALL count cycles in BURST with no ack, clearing on each ack; at TIMEOUT, drop cyc/stb, go to ERR, pulse err_o 1 cycle, then IDLE.
REQ-024 cmd_ready_o SHALL be 0 in BURST/DONE/ERR; a back-to-back command is accepted no earlier than the cycle after DONE.

Reset
REQ-025 With wb_rst_n=0 at an edge: state=IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rdat_valid_o, done_o, err_o, wdat_ready_o =0; wb_cti_o=000; wb_bte_o=00; wb_adr_o, wb_dat_o, wb_sel_o, rdat_o =0; counters =0; cmd_ready_o=0 during reset.
REQ-026 Reset mid-burst SHALL drop cyc/stb in the cycle after the reset edge, with no done_o/err_o and the partial beats discarded.

Structure
REQ-027 The wb_cti/wb_bte encodings (CLASSIC, INC_BURST, END_BURST, LINEAR) SHALL live in a shared wb_common package reused by the arbiter.
REQ-028 The watchdog SHALL be a sub-module wb_watchdog (parameter TIMEOUT; inputs clear/enable; output expired); all else in one module.

Verification
REQ-029 Read 4 @0x0000_1000, slave acks every cycle -> adr 1000,1004,1008,100C; cti 010,010,010,111; 4 rdat_valid; done_o 1 cycle.
REQ-030 Write 8 @0x0000_0200, wdat_valid gapped 1-of-2 -> stb gaps and cti held; dat/sel stable until ack; 8 acks; done_o.
REQ-031 Read 1 @0xFFFF_FFFC -> cti 000; done; then read 2 @0xFFFF_FFFC -> adr FFFF_FFFC, 0000_0000 (wrap).
REQ-032 Read 2 with slave never acking, TIMEOUT=16 -> cyc drops after 16 cycles; err_o pulses 1; no done_o; cmd_ready_o returns 1.
REQ-033 wb_rst_n=0 after 3 of 8 write acks -> cyc/stb=0 next cycle; all outputs at reset values; next command starts cleanly.
REQ-034 cmd_len_i=0 read -> exactly MAX_BURST(8) beats; spurious ack while stb=0 -> ignored.
